// File: rtl/coproc_cmd_sched_if.sv
// Handshake and held configuration between the command sequencer and the image coprocessor.
interface coproc_cmd_sched_if;
  logic       coproc_rdy;
  logic       coproc_done;
  logic       coproc_start;
  logic       coproc_gray;
  logic       coproc_img_idx;
  logic [2:0] coproc_func;

  modport master (
    input  coproc_rdy, coproc_done,
    output coproc_start, coproc_gray, coproc_img_idx, coproc_func
  );

  modport slave (
    output coproc_rdy, coproc_done,
    input  coproc_start, coproc_gray, coproc_img_idx, coproc_func
  );
endinterface

// File: rtl/coproc_cmd_sched.sv
// Coprocessor command FIFO and sequencer: issues queued commands one at a time,
// holds their configuration until done and aborts stuck commands with a watchdog.
module coproc_cmd_sched #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1000000,
  parameter int TMO_W   = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_wr,
  input  logic [7:0]               cmd_data,
  input  logic                     clr_err,
  input  logic                     bootloading,
  coproc_cmd_sched_if.master       cp,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     q_full,
  output logic                     ovf_err,
  output logic                     tmo_err,
  output logic [7:0]               done_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic       gray;
    logic       img_idx;
    logic [2:0] func;
  } cmd_t;

  typedef enum logic {IDLE, WAIT_DONE} state_t;

  state_t           state_q, state_d;
  cmd_t             mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [TMO_W-1:0] tmo_cnt;
  logic             empty;
  logic             pop, push, ovf_set;
  logic             done_evt, tmo_evt, cnt_inc;
  logic             unused_cmd_bits;

  assign unused_cmd_bits = ^{cmd_data[7], cmd_data[4:3]};

  assign empty  = (q_count == '0);
  assign q_full = (q_count == CW'(DEPTH));
  assign busy   = (state_q == WAIT_DONE);

  // A full queue still takes a push when the head leaves in the same cycle.
  assign push    = cmd_wr && !bootloading && (!q_full || pop);
  assign ovf_set = cmd_wr && !bootloading && q_full && !pop;

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    done_evt = 1'b0;
    tmo_evt  = 1'b0;
    cnt_inc  = 1'b0;
    if (bootloading) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty && cp.coproc_rdy) begin
            pop     = 1'b1;
            state_d = WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // A done overlapping the start pulse belongs to no command of ours.
          if (cp.coproc_done && !cp.coproc_start) begin
            done_evt = 1'b1;
            state_d  = IDLE;
          end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            tmo_evt = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{gray: cmd_data[6], img_idx: cmd_data[5], func: cmd_data[2:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      q_count           <= '0;
      tmo_cnt           <= '0;
      cp.coproc_start   <= 1'b0;
      cp.coproc_gray    <= 1'b0;
      cp.coproc_img_idx <= 1'b0;
      cp.coproc_func    <= '0;
      ovf_err           <= 1'b0;
      tmo_err           <= 1'b0;
      done_cnt          <= '0;
    end else begin
      state_q         <= state_d;
      cp.coproc_start <= pop;
      if (bootloading) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        q_count <= '0;
        tmo_cnt <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          rd_ptr            <= rd_ptr + 1'b1;
          cp.coproc_gray    <= mem[rd_ptr].gray;
          cp.coproc_img_idx <= mem[rd_ptr].img_idx;
          cp.coproc_func    <= mem[rd_ptr].func;
          tmo_cnt           <= '0;
        end else if (cnt_inc) begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
        if (push && !pop)      q_count <= q_count + CW'(1);
        else if (pop && !push) q_count <= q_count - CW'(1);
      end
      if (done_evt) done_cnt <= done_cnt + 8'd1;
      // A fresh error event outranks a clear in the same cycle.
      ovf_err <= ovf_set | (ovf_err & ~clr_err);
      tmo_err <= tmo_evt | (tmo_err & ~clr_err);
    end
  end
endmodule

// File: tb/tb_coproc_cmd_sched.sv
// Directed and randomized checks of coproc_cmd_sched against a queue-based reference model.
module tb_coproc_cmd_sched;
  localparam int DEPTH = 4, TIMEOUT = 16, TMO_W = 5;

  logic       clk = 1'b0;
  logic       rst, cmd_wr, clr_err, bootloading;
  logic [7:0] cmd_data;
  logic       busy, q_full, ovf_err, tmo_err;
  logic [2:0] q_count;
  logic [7:0] done_cnt;

  coproc_cmd_sched_if cp();

  coproc_cmd_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst(rst), .cmd_wr(cmd_wr), .cmd_data(cmd_data), .clr_err(clr_err),
    .bootloading(bootloading), .cp(cp), .busy(busy), .q_count(q_count), .q_full(q_full),
    .ovf_err(ovf_err), .tmo_err(tmo_err), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: pending commands as a queue, in-flight command as a flag plus its age.
  int m_q[$];
  bit m_busy, m_start, m_gray, m_img, m_ovf, m_tmo;
  int m_age, m_func, m_dcnt;

  task automatic model_edge();
    bit pop, full, done_ok;
    int v;
    if (rst) begin
      m_q.delete();
      m_busy = 0; m_start = 0; m_gray = 0; m_img = 0; m_ovf = 0; m_tmo = 0;
      m_age = 0; m_func = 0; m_dcnt = 0;
    end else begin
      pop  = !bootloading && !m_busy && m_q.size() > 0 && cp.coproc_rdy;
      full = (m_q.size() == DEPTH);
      if (clr_err) begin m_ovf = 0; m_tmo = 0; end
      if (bootloading) begin
        m_q.delete();
        m_busy = 0;
      end else begin
        done_ok = m_busy && cp.coproc_done && !m_start;
        if (done_ok) begin
          m_dcnt = (m_dcnt + 1) % 256;
          m_busy = 0;
        end else if (m_busy && m_age == TIMEOUT - 1) begin
          m_tmo  = 1;
          m_busy = 0;
        end else if (m_busy) begin
          m_age++;
        end
        if (pop) begin
          v = m_q.pop_front();
          m_gray = v[6]; m_img = v[5]; m_func = v & 7;
          m_busy = 1; m_age = 0;
        end
        if (cmd_wr) begin
          if (!full || pop) m_q.push_back(int'(cmd_data));
          else m_ovf = 1;
        end
      end
      m_start = pop;
    end
  endtask

  task automatic compare_all();
    chk("start",   int'(cp.coproc_start),   int'(m_start));
    chk("gray",    int'(cp.coproc_gray),    int'(m_gray));
    chk("img_idx", int'(cp.coproc_img_idx), int'(m_img));
    chk("func",    int'(cp.coproc_func),    m_func);
    chk("busy",    int'(busy),              int'(m_busy));
    chk("q_count", int'(q_count),           m_q.size());
    chk("q_full",  int'(q_full),            int'(m_q.size() == DEPTH));
    chk("ovf_err", int'(ovf_err),           int'(m_ovf));
    chk("tmo_err", int'(tmo_err),           int'(m_tmo));
    chk("done_cnt", int'(done_cnt),         m_dcnt);
  endtask

  // One clock: inputs were set #1 after the previous edge; pulses drop after the check.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    cmd_wr = 0; clr_err = 0; cp.coproc_done = 0;
  endtask

  task automatic push(input logic [7:0] d);
    cmd_wr = 1; cmd_data = d;
    tick();
  endtask

  task automatic do_reset();
    rst = 1; bootloading = 0; cp.coproc_rdy = 0;
    tick();
    rst = 0;
  endtask

  int funcs[$];
  int n;

  initial begin
    rst = 1; cmd_wr = 0; cmd_data = 0; clr_err = 0; bootloading = 0;
    cp.coproc_rdy = 0; cp.coproc_done = 0;
    #1;

    // Single command 0x43, done 10 cycles after start.
    do_reset();
    chk("rst_busy", int'(busy), 0);
    chk("rst_dcnt", int'(done_cnt), 0);
    cp.coproc_rdy = 1;
    push(8'h43);
    chk("lat_nostart", int'(cp.coproc_start), 0);
    tick();
    chk("lat_start", int'(cp.coproc_start), 1);
    chk("cfg_func", int'(cp.coproc_func), 3);
    chk("cfg_gray", int'(cp.coproc_gray), 1);
    chk("cfg_img", int'(cp.coproc_img_idx), 0);
    for (int i = 0; i < 10; i++) tick();
    chk("start_once", int'(cp.coproc_start), 0);
    chk("busy_wait", int'(busy), 1);
    cp.coproc_done = 1;
    tick();
    chk("busy_after_done", int'(busy), 0);
    chk("dcnt_one", int'(done_cnt), 1);
    chk("cfg_hold", int'(cp.coproc_func), 3);

    // Overflow: five pushes with rdy low, then drain in order.
    do_reset();
    for (int i = 1; i <= 5; i++) push(8'(i));
    chk("ovf_qcnt", int'(q_count), 4);
    chk("ovf_full", int'(q_full), 1);
    chk("ovf_flag", int'(ovf_err), 1);
    cp.coproc_rdy = 1;
    funcs.delete();
    n = 0;
    while (done_cnt != 8'd4 && n < 80) begin
      cp.coproc_done = busy && !cp.coproc_start;
      tick();
      if (cp.coproc_start) funcs.push_back(int'(cp.coproc_func));
      n++;
    end
    chk("drain_n", funcs.size(), 4);
    for (int i = 0; i < funcs.size() && i < 4; i++) chk("drain_func", funcs[i], i + 1);
    chk("drain_dcnt", int'(done_cnt), 4);

    // Push into a full queue in the same cycle as a pop.
    do_reset();
    for (int i = 1; i <= 4; i++) push(8'(i));
    cp.coproc_rdy = 1;
    push(8'h06);
    chk("pp_qcnt", int'(q_count), 4);
    chk("pp_ovf", int'(ovf_err), 0);
    chk("pp_start", int'(cp.coproc_start), 1);
    funcs.delete();
    funcs.push_back(int'(cp.coproc_func));
    n = 0;
    while (done_cnt != 8'd5 && n < 80) begin
      cp.coproc_done = busy && !cp.coproc_start;
      tick();
      if (cp.coproc_start) funcs.push_back(int'(cp.coproc_func));
      n++;
    end
    chk("pp_n", funcs.size(), 5);
    if (funcs.size() == 5) chk("pp_last", funcs[4], 6);

    // Watchdog expiry, then done coinciding with expiry.
    do_reset();
    cp.coproc_rdy = 1;
    push(8'h01);
    push(8'h02);
    chk("tmo_start", int'(cp.coproc_start), 1);
    n = 0;
    while (!tmo_err && n < 40) begin
      tick();
      n++;
    end
    chk("tmo_cycles", n, 16);
    chk("tmo_busy", int'(busy), 0);
    chk("tmo_dcnt", int'(done_cnt), 0);
    tick();
    chk("tmo_next_start", int'(cp.coproc_start), 1);
    chk("tmo_next_func", int'(cp.coproc_func), 2);
    clr_err = 1;
    for (int i = 0; i < 15; i++) tick();
    chk("tmo_race_busy", int'(busy), 1);
    cp.coproc_done = 1;
    tick();
    chk("race_dcnt", int'(done_cnt), 1);
    chk("race_tmo", int'(tmo_err), 0);
    chk("race_busy", int'(busy), 0);

    // Bootloading during WAIT_DONE with commands still queued.
    do_reset();
    cp.coproc_rdy = 1;
    for (int i = 1; i <= 4; i++) push(8'(i));
    tick();
    chk("boot_pre_q", int'(q_count), 3);
    chk("boot_pre_busy", int'(busy), 1);
    bootloading = 1;
    push(8'h07);
    chk("boot_q", int'(q_count), 0);
    chk("boot_busy", int'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      push(8'h05);
      chk("boot_nostart", int'(cp.coproc_start), 0);
      chk("boot_noovf", int'(ovf_err), 0);
    end
    bootloading = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_boot_start", int'(cp.coproc_start), 0);
    end
    chk("post_boot_q", int'(q_count), 0);
    chk("boot_cfg_kept", int'(cp.coproc_func), 1);

    // Error clearing and reset while busy.
    do_reset();
    for (int i = 1; i <= 5; i++) push(8'(i));
    chk("clr_pre", int'(ovf_err), 1);
    clr_err = 1;
    tick();
    chk("clr_alone", int'(ovf_err), 0);
    clr_err = 1;
    push(8'h09);
    chk("clr_vs_ovf", int'(ovf_err), 1);
    cp.coproc_rdy = 1;
    tick();
    tick();
    chk("rst_pre_busy", int'(busy), 1);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_q", int'(q_count), 0);
    chk("rst_mid_ovf", int'(ovf_err), 0);
    chk("rst_mid_func", int'(cp.coproc_func), 0);

    // Random traffic; the long reset-free stretch lets done_cnt wrap.
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      rst           = (i > 4500) && ($urandom_range(199) == 0);
      cmd_wr        = ($urandom_range(99) < 40);
      cmd_data      = 8'($urandom);
      clr_err       = ($urandom_range(99) < 5);
      bootloading   = ($urandom_range(99) < 3);
      cp.coproc_rdy = ($urandom_range(99) < 75);
      cp.coproc_done = busy ? ($urandom_range(99) < 35) : ($urandom_range(99) < 2);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
